// File: rtl/rgb_yuv_pkg.sv
// Shared types and constants for the RGB -> YUV (BT.601 studio range) converter.
// Clamp limits for both the full-range and RGB2YUV_STUDIO_CLAMP_EN builds live here.
package rgb_yuv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC_R,
        MAC_G,
        MAC_B,
        OUT
    } state_t;

    // Coefficients x65536, columns R, G, B
    localparam int signed CY_R = 16843;
    localparam int signed CY_G = 33030;
    localparam int signed CY_B = 6423;
    localparam int signed CU_R = -9699;
    localparam int signed CU_G = -19071;
    localparam int signed CU_B = 28770;
    localparam int signed CV_R = 28770;
    localparam int signed CV_G = -24117;
    localparam int signed CV_B = -4653;

    localparam int signed ROUND_CONST = 32768;
    localparam int signed Y_OFFSET    = 16;
    localparam int signed C_OFFSET    = 128;

    localparam logic [7:0] Y_MIN_STUDIO = 8'd16;
    localparam logic [7:0] Y_MAX_STUDIO = 8'd235;
    localparam logic [7:0] C_MIN_STUDIO = 8'd16;
    localparam logic [7:0] C_MAX_STUDIO = 8'd240;
    localparam logic [7:0] FULL_MIN     = 8'd0;
    localparam logic [7:0] FULL_MAX     = 8'd255;

    function automatic logic [7:0] clamp_lo(input logic studio, input logic luma);
        return studio ? (luma ? Y_MIN_STUDIO : C_MIN_STUDIO) : FULL_MIN;
    endfunction

    function automatic logic [7:0] clamp_hi(input logic studio, input logic luma);
        return studio ? (luma ? Y_MAX_STUDIO : C_MAX_STUDIO) : FULL_MAX;
    endfunction

endpackage

// File: rtl/yuv_clamp8.sv
// Saturates a signed accumulator-width value into an 8-bit unsigned range [lo, hi].
module yuv_clamp8
    #(
        parameter int ACC_W = 32
    )
    (
        input  logic signed [ACC_W-1:0] value,
        input  logic        [7:0]       lo,
        input  logic        [7:0]       hi,
        output logic        [7:0]       result
    );

    logic signed [ACC_W-1:0] lo_ext;
    logic signed [ACC_W-1:0] hi_ext;

    assign lo_ext = $signed({{(ACC_W-8){1'b0}}, lo});
    assign hi_ext = $signed({{(ACC_W-8){1'b0}}, hi});

    always_comb begin
        if (value < lo_ext) begin
            result = lo;
        end else if (value > hi_ext) begin
            result = hi;
        end else begin
            result = value[7:0];
        end
    end

endmodule

// File: rtl/rgb_to_yuv_converter.sv
// RGB -> YUV converter: three shared multipliers stepped over R, G, B, valid/ready on both sides.
// Define RGB2YUV_STUDIO_CLAMP_EN to clamp Y to 16..235 and U/V to 16..240 instead of 0..255.
module rgb_to_yuv_converter
    import rgb_yuv_pkg::*;
    #(
        parameter int COEFF_W = 18,
        parameter int ACC_W   = 32
    )
    (
        input  logic       CLOCK_50_I,
        input  logic       resetn,
        input  logic       sync_clear,
        input  logic       in_valid,
        output logic       in_ready,
        input  logic [7:0] R_in,
        input  logic [7:0] G_in,
        input  logic [7:0] B_in,
        output logic       out_valid,
        input  logic       out_ready,
        output logic [7:0] Y_out,
        output logic [7:0] U_out,
        output logic [7:0] V_out
    );

`ifdef RGB2YUV_STUDIO_CLAMP_EN
    localparam logic STUDIO = 1'b1;
`else
    localparam logic STUDIO = 1'b0;
`endif

    localparam logic [7:0] Y_LO = clamp_lo(STUDIO, 1'b1);
    localparam logic [7:0] Y_HI = clamp_hi(STUDIO, 1'b1);
    localparam logic [7:0] C_LO = clamp_lo(STUDIO, 1'b0);
    localparam logic [7:0] C_HI = clamp_hi(STUDIO, 1'b0);

    state_t state;

    logic        [7:0]         r_cap, g_cap, b_cap, pix;
    logic signed [COEFF_W-1:0] coef_y, coef_u, coef_v;
    logic signed [ACC_W-1:0]   pix_ext;
    logic signed [ACC_W-1:0]   acc_y, acc_u, acc_v;
    logic signed [ACC_W-1:0]   prod_y, prod_u, prod_v;
    logic signed [ACC_W-1:0]   sum_y, sum_u, sum_v;
    logic signed [ACC_W-1:0]   pre_y, pre_u, pre_v;
    logic        [7:0]         y_clamped, u_clamped, v_clamped;

    // Operand select: the MAC state picks which captured channel and coefficient column feed the multipliers
    always_comb begin
        pix    = '0;
        coef_y = '0;
        coef_u = '0;
        coef_v = '0;
        case (state)
            MAC_R: begin
                pix    = r_cap;
                coef_y = COEFF_W'(CY_R);
                coef_u = COEFF_W'(CU_R);
                coef_v = COEFF_W'(CV_R);
            end
            MAC_G: begin
                pix    = g_cap;
                coef_y = COEFF_W'(CY_G);
                coef_u = COEFF_W'(CU_G);
                coef_v = COEFF_W'(CV_G);
            end
            MAC_B: begin
                pix    = b_cap;
                coef_y = COEFF_W'(CY_B);
                coef_u = COEFF_W'(CU_B);
                coef_v = COEFF_W'(CV_B);
            end
            default: ;
        endcase
    end

    assign pix_ext = $signed({{(ACC_W-8){1'b0}}, pix});
    assign prod_y  = pix_ext * ACC_W'(coef_y);
    assign prod_u  = pix_ext * ACC_W'(coef_u);
    assign prod_v  = pix_ext * ACC_W'(coef_v);

    assign sum_y = acc_y + prod_y;
    assign sum_u = acc_u + prod_u;
    assign sum_v = acc_v + prod_v;

    // Arithmetic shift floors; the rounding constant preloaded into the accumulators makes it round-to-nearest
    assign pre_y = (sum_y >>> 16) + ACC_W'(Y_OFFSET);
    assign pre_u = (sum_u >>> 16) + ACC_W'(C_OFFSET);
    assign pre_v = (sum_v >>> 16) + ACC_W'(C_OFFSET);

    yuv_clamp8 #(.ACC_W(ACC_W)) u_clamp_y (.value(pre_y), .lo(Y_LO), .hi(Y_HI), .result(y_clamped));
    yuv_clamp8 #(.ACC_W(ACC_W)) u_clamp_u (.value(pre_u), .lo(C_LO), .hi(C_HI), .result(u_clamped));
    yuv_clamp8 #(.ACC_W(ACC_W)) u_clamp_v (.value(pre_v), .lo(C_LO), .hi(C_HI), .result(v_clamped));

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Y_out     <= 8'(Y_OFFSET);
            U_out     <= 8'(C_OFFSET);
            V_out     <= 8'(C_OFFSET);
            acc_y     <= '0;
            acc_u     <= '0;
            acc_v     <= '0;
            r_cap     <= '0;
            g_cap     <= '0;
            b_cap     <= '0;
        end else if (sync_clear) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc_y     <= '0;
            acc_u     <= '0;
            acc_v     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_cap    <= R_in;
                        g_cap    <= G_in;
                        b_cap    <= B_in;
                        acc_y    <= ACC_W'(ROUND_CONST);
                        acc_u    <= ACC_W'(ROUND_CONST);
                        acc_v    <= ACC_W'(ROUND_CONST);
                        in_ready <= 1'b0;
                        state    <= MAC_R;
                    end
                end
                MAC_R, MAC_G: begin
                    acc_y <= sum_y;
                    acc_u <= sum_u;
                    acc_v <= sum_v;
                    state <= (state == MAC_R) ? MAC_G : MAC_B;
                end
                MAC_B: begin
                    acc_y     <= sum_y;
                    acc_u     <= sum_u;
                    acc_v     <= sum_v;
                    Y_out     <= y_clamped;
                    U_out     <= u_clamped;
                    V_out     <= v_clamped;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_to_yuv_converter.sv
// Self-checking bench for rgb_to_yuv_converter: directed corner pixels plus random pixels
// with random backpressure, compared against a plain-arithmetic BT.601 reference.
module tb_rgb_to_yuv_converter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sync_clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] r_in, g_in, b_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out, u_out, v_out;

    int checks   = 0;
    int failures = 0;
    int last_y   = 16;
    int last_u   = 128;
    int last_v   = 128;

`ifdef RGB2YUV_STUDIO_CLAMP_EN
    localparam int Y_LO = 16, Y_HI = 235, C_LO = 16, C_HI = 240;
`else
    localparam int Y_LO = 0, Y_HI = 255, C_LO = 0, C_HI = 255;
`endif

    rgb_to_yuv_converter dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .sync_clear (sync_clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .R_in       (r_in),
        .G_in       (g_in),
        .B_in       (b_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Y_out      (y_out),
        .U_out      (u_out),
        .V_out      (v_out)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp_ref(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Weighted sum with rounding, floored division by 65536, then offset and clamp
    function automatic int conv_ref(input int kr, input int kg, input int kb, input int off,
                                    input int lo, input int hi, input int r, input int g, input int b);
        int acc;
        acc = kr * r + kg * g + kb * b + 32768;
        return clamp_ref((acc >>> 16) + off, lo, hi);
    endfunction

    // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic run_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int hold);
        int ey, eu, ev, lat, leak;
        ey = conv_ref(16843, 33030, 6423, 16, Y_LO, Y_HI, int'(r), int'(g), int'(b));
        eu = conv_ref(-9699, -19071, 28770, 128, C_LO, C_HI, int'(r), int'(g), int'(b));
        ev = conv_ref(28770, -24117, -4653, 128, C_LO, C_HI, int'(r), int'(g), int'(b));
        check("idle_in_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        r_in = r;
        g_in = g;
        b_in = b;
        @(negedge clk);
        // junk held on in_valid while busy must be ignored
        r_in = 8'($urandom);
        g_in = 8'($urandom);
        b_in = 8'($urandom);
        out_ready = (hold == 0);
        lat  = 1;
        leak = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) leak = 1;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 4);
        check("busy_in_ready", leak, 0);
        check("y", int'(y_out), ey);
        check("u", int'(u_out), eu);
        check("v", int'(v_out), ev);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_y", int'(y_out), ey);
            check("hold_u", int'(u_out), eu);
            check("hold_v", int'(v_out), ev);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", int'(out_valid), 0);
        check("ready_back", int'(in_ready), 1);
        last_y = ey;
        last_u = eu;
        last_v = ev;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        resetn     = 1'b1;
        sync_clear = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        #2 resetn = 1'b0;
        #3;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y", int'(y_out), 16);
        check("rst_u", int'(u_out), 128);
        check("rst_v", int'(v_out), 128);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_pixel(8'd0,   8'd0,   8'd0,   0);
        check("black_y_const", int'(y_out), 16);
        run_pixel(8'd255, 8'd255, 8'd255, 0);
        check("white_y_const", int'(y_out), 235);
        run_pixel(8'd255, 8'd0,   8'd0,   0);
        check("red_u_const", int'(u_out), 90);
        run_pixel(8'd0,   8'd0,   8'd255, 0);
        check("blue_v_const", int'(v_out), 110);
        run_pixel(8'd0,   8'd255, 8'd0,   0);
        check("green_u_const", int'(u_out), 54);
        run_pixel(8'd37,  8'd142, 8'd201, 10);
        run_pixel(8'd200, 8'd10,  8'd99,  0);

        // abort while in MAC_G
        in_valid = 1'b1;
        r_in = 8'd10;
        g_in = 8'd200;
        b_in = 8'd50;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        sync_clear = 1'b1;
        @(negedge clk);
        sync_clear = 1'b0;
        check("clr_in_ready", int'(in_ready), 1);
        check("clr_out_valid", int'(out_valid), 0);
        check("clr_y_kept", int'(y_out), last_y);
        check("clr_u_kept", int'(u_out), last_u);
        check("clr_v_kept", int'(v_out), last_v);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("clr_no_valid", seen, 0);
        run_pixel(8'd255, 8'd0, 8'd0, 0);

        // asynchronous reset mid-operation
        in_valid = 1'b1;
        r_in = 8'd90;
        g_in = 8'd30;
        b_in = 8'd250;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_y", int'(y_out), 16);
        check("mid_rst_u", int'(u_out), 128);
        check("mid_rst_v", int'(v_out), 128);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("mid_rst_no_valid", seen, 0);

        for (int n = 0; n < 40; n++) begin
            run_pixel(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
